// File: rtl/core_br_pkg.sv
// Shared branch-unit definitions: funct3 encodings, BHT counter type and
// the 2-bit saturating counter update used by the history table.
package core_br_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t SNT = 2'b00;
    localparam bht_cnt_t WNT = 2'b01;
    localparam bht_cnt_t WT  = 2'b10;
    localparam bht_cnt_t ST  = 2'b11;

    function automatic bht_cnt_t sat_update(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t res;
        res = cnt;
        if (taken) begin
            if (cnt != ST) begin
                res = cnt + 2'd1;
            end
        end else begin
            if (cnt != SNT) begin
                res = cnt - 2'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table: 2-bit counters, two combinational read ports
// (fetch lookup, EX read-modify-write) and one synchronous write port.
module br_bht
    import core_br_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_a_idx,
    output bht_cnt_t         rd_a_cnt,
    input  logic [IDX_W-1:0] rd_b_idx,
    output bht_cnt_t         rd_b_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  bht_cnt_t         wr_cnt
);

    localparam int DEPTH = 2 ** IDX_W;

    bht_cnt_t cnt_reg [DEPTH];

    // Reset initialisation of every entry rules out a RAM primitive; this is a register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_reg[i] <= WNT;
            end
        end else if (wr_en) begin
            cnt_reg[wr_idx] <= wr_cnt;
        end
    end

    // No write bypass: a same-cycle read sees the pre-update counter.
    assign rd_a_cnt = cnt_reg[rd_a_idx];
    assign rd_b_cnt = cnt_reg[rd_b_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage conditional branches, trains the BHT and raises a
// registered one-cycle PC redirect whenever the fetch prediction was wrong.
module branch_resolve_unit
    import core_br_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      if_pc_i,
    output logic             if_pred_taken_o,
    input  logic             ex_valid_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [31:0]      ex_pc_i,
    input  logic [31:0]      ex_target_i,
    input  logic             ex_pred_taken_i,
    output logic             ex_br_unsigned_o,
    input  logic             br_less_i,
    input  logic             br_equal_i,
    output logic             ex_taken_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             illegal_br_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic             redirect_valid_reg;
    logic [31:0]      redirect_pc_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] branch_cnt_reg;
    logic [CNT_W-1:0] mispred_cnt_reg;

    logic             taken_raw;
    logic             f3_legal;
    logic             res;
    logic             mispred;
    logic [31:0]      fix_pc;
    bht_cnt_t         if_cnt;
    bht_cnt_t         ex_cnt;
    bht_cnt_t         ex_cnt_next;
    logic             unused_pc_bits;

    assign ex_br_unsigned_o = ex_funct3_i[1];

    always_comb begin
        taken_raw = 1'b0;
        case (ex_funct3_i)
            F3_BEQ:           taken_raw = br_equal_i;
            F3_BNE:           taken_raw = !br_equal_i;
            F3_BLT, F3_BLTU:  taken_raw = br_less_i;
            F3_BGE, F3_BGEU:  taken_raw = !br_less_i;
            default:          taken_raw = 1'b0;
        endcase
    end

    // 010 and 011 are the only unused encodings in the branch major opcode.
    assign f3_legal   = (ex_funct3_i[2:1] != 2'b01);
    assign ex_taken_o = ex_valid_i && taken_raw;

    // The instruction behind a mispredict is wrong-path and must leave no trace.
    assign res     = ex_valid_i && !redirect_valid_reg;
    assign mispred = f3_legal ? (ex_taken_o != ex_pred_taken_i) : ex_pred_taken_i;
    assign fix_pc  = (f3_legal && taken_raw) ? ex_target_i : (ex_pc_i + 32'd4);

    assign ex_cnt_next = sat_update(ex_cnt, ex_taken_o);

    br_bht #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk_i),
        .rst      (rst_i),
        .rd_a_idx (if_pc_i[IDX_W+1:2]),
        .rd_a_cnt (if_cnt),
        .rd_b_idx (ex_pc_i[IDX_W+1:2]),
        .rd_b_cnt (ex_cnt),
        .wr_en    (res && f3_legal),
        .wr_idx   (ex_pc_i[IDX_W+1:2]),
        .wr_cnt   (ex_cnt_next)
    );

    assign if_pred_taken_o = if_cnt[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= 32'd0;
            illegal_reg        <= 1'b0;
            branch_cnt_reg     <= '0;
            mispred_cnt_reg    <= '0;
        end else begin
            redirect_valid_reg <= res && mispred;
            illegal_reg        <= res && !f3_legal;
            if (res && mispred) begin
                redirect_pc_reg <= fix_pc;
                mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
            end
            if (res && f3_legal) begin
                branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign redirect_valid_o = redirect_valid_reg;
    assign redirect_pc_o    = redirect_pc_reg;
    assign illegal_br_o     = illegal_reg;
    assign branch_cnt_o     = branch_cnt_reg;
    assign mispred_cnt_o    = mispred_cnt_reg;

    assign unused_pc_bits = ^{if_pc_i[31:IDX_W+2], if_pc_i[1:0],
                              ex_pc_i[31:IDX_W+2], ex_pc_i[1:0], if_cnt[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: expected redirects are queued at
// issue time and a negedge monitor matches them against DUT redirect pulses.
module tb_branch_resolve_unit;
    import core_br_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic        if_pred_taken_o;
    logic        ex_valid_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic        ex_br_unsigned_o;
    logic        br_less_i;
    logic        br_equal_i;
    logic        ex_taken_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        illegal_br_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    typedef struct {
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.IDX_W(6), .CNT_W(32)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .if_pc_i          (if_pc_i),
        .if_pred_taken_o  (if_pred_taken_o),
        .ex_valid_i       (ex_valid_i),
        .ex_funct3_i      (ex_funct3_i),
        .ex_pc_i          (ex_pc_i),
        .ex_target_i      (ex_target_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .ex_br_unsigned_o (ex_br_unsigned_o),
        .br_less_i        (br_less_i),
        .br_equal_i       (br_equal_i),
        .ex_taken_o       (ex_taken_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .illegal_br_o     (illegal_br_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic less, input logic eq);
        ex_valid_i      = 1'b1;
        ex_funct3_i     = f3;
        ex_pc_i         = pc;
        ex_target_i     = tgt;
        ex_pred_taken_i = pred;
        br_less_i       = less;
        br_equal_i      = eq;
        if_pc_i         = pc;
    endtask

    task automatic idle();
        ex_valid_i      = 1'b0;
        ex_pred_taken_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic ill);
        exp_t e;
        e.pc  = pc;
        e.ill = ill;
        exp_q.push_back(e);
    endtask

    // Monitor: every redirect or illegal pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (redirect_valid_o === 1'b1 || illegal_br_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_redirect: got valid=%0b pc=0x%08h ill=%0b expected none",
                         redirect_valid_o, redirect_pc_o, illegal_br_o);
            end else begin
                mon_e = exp_q.pop_front();
                $display("redirect pc=0x%08h illegal=%0b (expected pc=0x%08h illegal=%0b)",
                         redirect_pc_o, illegal_br_o, mon_e.pc, mon_e.ill);
                chk("mon_redirect_valid", {31'd0, redirect_valid_o}, 32'd1);
                chk("mon_redirect_pc", redirect_pc_o, mon_e.pc);
                chk("mon_illegal", {31'd0, illegal_br_o}, {31'd0, mon_e.ill});
            end
        end
    end

    int          bne_eq   [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    int          bne_pred [10] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [31:0] bne_rpc  [10] = '{32'h180, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h84, 32'h84, 32'h0, 32'h0, 32'h180};

    initial begin
        rst_i = 1'b1;
        if_pc_i = 32'd0;
        ex_valid_i = 1'b0;
        ex_funct3_i = 3'd0;
        ex_pc_i = 32'd0;
        ex_target_i = 32'd0;
        ex_pred_taken_i = 1'b0;
        br_less_i = 1'b0;
        br_equal_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        if_pc_i = 32'h40;
        #1;
        chk("reset_pred", {31'd0, if_pred_taken_o}, 32'd0);
        chk("reset_branch_cnt", branch_cnt_o, 32'd0);
        chk("reset_mispred_cnt", mispred_cnt_o, 32'd0);
        chk("reset_redirect_valid", {31'd0, redirect_valid_o}, 32'd0);
        chk("reset_redirect_pc", redirect_pc_o, 32'd0);
        chk("reset_illegal", {31'd0, illegal_br_o}, 32'd0);
        tick();

        // BEQ taken, predicted not-taken
        drive(F3_BEQ, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
        #1;
        chk("beq_taken", {31'd0, ex_taken_o}, 32'd1);
        chk("beq_unsigned", {31'd0, ex_br_unsigned_o}, 32'd0);
        chk("beq_lookup", {31'd0, if_pred_taken_o}, 32'd0);
        push_exp(32'h200, 1'b0);
        tick();
        idle();
        if_pc_i = 32'h100;
        #1;
        chk("beq_pred_after", {31'd0, if_pred_taken_o}, 32'd1);
        chk("beq_mispred_cnt", mispred_cnt_o, 32'd1);
        chk("beq_branch_cnt", branch_cnt_o, 32'd1);
        tick();

        // BGEU not taken (less=1), predicted taken -> fall-through
        drive(F3_BGEU, 32'h300, 32'h500, 1'b1, 1'b1, 1'b0);
        #1;
        chk("bgeu_unsigned", {31'd0, ex_br_unsigned_o}, 32'd1);
        chk("bgeu_taken", {31'd0, ex_taken_o}, 32'd0);
        push_exp(32'h304, 1'b0);
        tick();
        idle();
        ex_funct3_i = F3_BLT;
        br_less_i = 1'b1;
        if_pc_i = 32'h300;
        #1;
        chk("blt_unsigned", {31'd0, ex_br_unsigned_o}, 32'd0);
        chk("invalid_not_taken", {31'd0, ex_taken_o}, 32'd0);
        chk("bgeu_pred_after", {31'd0, if_pred_taken_o}, 32'd0);
        chk("bgeu_branch_cnt", branch_cnt_o, 32'd2);
        chk("bgeu_mispred_cnt", mispred_cnt_o, 32'd2);
        tick();

        // BNE training run at 0x80: saturate up, then down to 00
        for (int i = 0; i < 10; i++) begin
            drive(F3_BNE, 32'h80, 32'h180, bne_pred[i][0], 1'b0, bne_eq[i][0]);
            #1;
            chk($sformatf("bne_lookup_%0d", i), {31'd0, if_pred_taken_o}, 32'(bne_pred[i]));
            chk($sformatf("bne_taken_%0d", i), {31'd0, ex_taken_o}, 32'(1 - bne_eq[i]));
            if (bne_rpc[i] != 32'd0) begin
                push_exp(bne_rpc[i], 1'b0);
            end
            tick();
            if (bne_rpc[i] != 32'd0) begin
                idle();
                tick();
            end
        end
        idle();
        if_pc_i = 32'h80;
        #1;
        chk("bne_final_pred", {31'd0, if_pred_taken_o}, 32'd0);
        chk("bne_branch_cnt", branch_cnt_o, 32'd12);
        chk("bne_mispred_cnt", mispred_cnt_o, 32'd6);
        tick();

        // Mispredict followed immediately by a wrong-path branch
        drive(F3_BEQ, 32'h40, 32'h400, 1'b0, 1'b0, 1'b1);
        #1;
        chk("squash_lookup", {31'd0, if_pred_taken_o}, 32'd0);
        push_exp(32'h400, 1'b0);
        tick();
        drive(F3_BEQ, 32'h40, 32'h400, 1'b1, 1'b0, 1'b0);
        #1;
        chk("squash_redirect_cycle", {31'd0, redirect_valid_o}, 32'd1);
        tick();
        idle();
        if_pc_i = 32'h40;
        #1;
        chk("squash_no_redirect", {31'd0, redirect_valid_o}, 32'd0);
        chk("squash_pred", {31'd0, if_pred_taken_o}, 32'd1);
        chk("squash_branch_cnt", branch_cnt_o, 32'd13);
        chk("squash_mispred_cnt", mispred_cnt_o, 32'd7);
        tick();

        // Illegal funct3 predicted taken at the top of the address space
        drive(3'b010, 32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b1, 1'b1);
        #1;
        chk("illegal_taken", {31'd0, ex_taken_o}, 32'd0);
        push_exp(32'h0000_0000, 1'b1);
        tick();
        rst_i = 1'b1;
        drive(3'b011, 32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b1, 1'b1);
        #1;
        chk("f3_011_taken", {31'd0, ex_taken_o}, 32'd0);
        chk("illegal_pulse", {31'd0, illegal_br_o}, 32'd1);
        chk("illegal_redirect_pc", redirect_pc_o, 32'd0);
        chk("illegal_branch_cnt", branch_cnt_o, 32'd13);
        chk("illegal_mispred_cnt", mispred_cnt_o, 32'd8);
        chk("illegal_no_bht", {31'd0, if_pred_taken_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        idle();
        if_pc_i = 32'h40;
        #1;
        chk("rst2_redirect_valid", {31'd0, redirect_valid_o}, 32'd0);
        chk("rst2_redirect_pc", redirect_pc_o, 32'd0);
        chk("rst2_illegal", {31'd0, illegal_br_o}, 32'd0);
        chk("rst2_branch_cnt", branch_cnt_o, 32'd0);
        chk("rst2_mispred_cnt", mispred_cnt_o, 32'd0);
        chk("rst2_bht_init", {31'd0, if_pred_taken_o}, 32'd0);
        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
